// File: rtl/aes_gcm_pkg.sv
// aes_gcm_pkg: shared phase codes, FSM states, widths and the GCM inc32 helper
package aes_gcm_pkg;
  localparam int BLOCK_W = 128;
  localparam int KEY_SCHED_W = 1408;
  typedef enum logic [2:0] {
    PH_BUBBLE = 3'd0,
    PH_INIT   = 3'd1,
    PH_AAD    = 3'd2,
    PH_PT     = 3'd3,
    PH_FINAL  = 3'd4
  } phase_e;
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_AAD, S_PT, S_FINAL} state_e;
  function automatic logic [0:BLOCK_W-1] fn_inc32(input logic [0:BLOCK_W-1] b);
    return {b[0:95], b[96:127] + 32'd1};
  endfunction
endpackage

// File: rtl/aes_gcm_pipeline_scheduler.sv
// aes_gcm_pipeline_scheduler: sequences header, AAD and PT blocks into one registered pipeline slot per clock
module aes_gcm_pipeline_scheduler
  import aes_gcm_pkg::*;
#(
  parameter int AAD_CNT_W = 16,
  parameter int PT_CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_hdr_valid,
  output logic                   o_hdr_ready,
  input  logic [0:KEY_SCHED_W-1] i_hdr_key_schedule,
  input  logic [0:BLOCK_W-1]     i_hdr_j0,
  input  logic [AAD_CNT_W-1:0]   i_hdr_aad_blocks,
  input  logic [PT_CNT_W-1:0]    i_hdr_pt_blocks,
  input  logic [0:BLOCK_W-1]     i_hdr_instance_size,
  input  logic                   i_aad_valid,
  output logic                   o_aad_ready,
  input  logic [0:BLOCK_W-1]     i_aad,
  input  logic                   i_pt_valid,
  output logic                   o_pt_ready,
  input  logic [0:BLOCK_W-1]     i_pt,
  output logic                   o_new_instance,
  output logic [0:2]             o_phase,
  output logic [0:KEY_SCHED_W-1] o_key_schedule,
  output logic [0:BLOCK_W-1]     o_plain_text,
  output logic [0:BLOCK_W-1]     o_aad,
  output logic [0:BLOCK_W-1]     o_h,
  output logic [0:BLOCK_W-1]     o_j0,
  output logic [0:BLOCK_W-1]     o_cb,
  output logic [0:BLOCK_W-1]     o_instance_size,
  output logic                   o_busy
);
  state_e state_q, state_d;
  phase_e phase_q, phase_d;
  logic new_q, new_d;
  logic [0:KEY_SCHED_W-1] key_q, key_d, key_out_q, key_out_d;
  logic [0:BLOCK_W-1] j0_q, j0_d, size_q, size_d, cb_q, cb_d;
  logic [0:BLOCK_W-1] j0_out_q, j0_out_d, size_out_q, size_out_d, cb_out_q, cb_out_d;
  logic [0:BLOCK_W-1] pt_out_q, pt_out_d, aad_out_q, aad_out_d;
  logic [AAD_CNT_W-1:0] aad_cnt_q, aad_cnt_d;
  logic [PT_CNT_W-1:0] pt_cnt_q, pt_cnt_d;
  logic hdr_xfer, aad_xfer, pt_xfer;
  assign o_hdr_ready = !rst && (state_q == S_IDLE || state_q == S_FINAL);
  assign o_aad_ready = !rst && state_q == S_AAD;
  assign o_pt_ready = !rst && state_q == S_PT;
  assign o_busy = state_q != S_IDLE;
  assign o_phase = phase_q;
  assign o_new_instance = new_q;
  assign o_key_schedule = key_out_q;
  assign o_j0 = j0_out_q;
  assign o_instance_size = size_out_q;
  assign o_cb = cb_out_q;
  assign o_plain_text = pt_out_q;
  assign o_aad = aad_out_q;
  assign o_h = '0;
  always_comb begin
    hdr_xfer = i_hdr_valid && o_hdr_ready;
    aad_xfer = i_aad_valid && o_aad_ready;
    pt_xfer = i_pt_valid && o_pt_ready;
    state_d = state_q;
    phase_d = PH_BUBBLE;
    new_d = 1'b0;
    key_d = hdr_xfer ? i_hdr_key_schedule : key_q;
    j0_d = hdr_xfer ? i_hdr_j0 : j0_q;
    size_d = hdr_xfer ? i_hdr_instance_size : size_q;
    aad_cnt_d = hdr_xfer ? i_hdr_aad_blocks : aad_cnt_q;
    pt_cnt_d = hdr_xfer ? i_hdr_pt_blocks : pt_cnt_q;
    cb_d = hdr_xfer ? fn_inc32(i_hdr_j0) : cb_q;
    // slot carries the instance in force when it was decided, so a FINAL slot keeps the old header
    key_out_d = key_q;
    j0_out_d = j0_q;
    size_out_d = size_q;
    cb_out_d = '0;
    pt_out_d = '0;
    aad_out_d = '0;
    case (state_q)
      S_IDLE: state_d = hdr_xfer ? S_INIT : S_IDLE;
      S_INIT: begin
        phase_d = PH_INIT;
        new_d = 1'b1;
        cb_out_d = j0_q;
        state_d = aad_cnt_q != '0 ? S_AAD : pt_cnt_q != '0 ? S_PT : S_FINAL;
      end
      S_AAD: if (aad_xfer) begin
        phase_d = PH_AAD;
        aad_out_d = i_aad;
        aad_cnt_d = aad_cnt_q - AAD_CNT_W'(1);
        state_d = aad_cnt_q != AAD_CNT_W'(1) ? S_AAD : pt_cnt_q != '0 ? S_PT : S_FINAL;
      end
      S_PT: if (pt_xfer) begin
        phase_d = PH_PT;
        pt_out_d = i_pt;
        cb_out_d = cb_q;
        cb_d = fn_inc32(cb_q);
        pt_cnt_d = pt_cnt_q - PT_CNT_W'(1);
        state_d = pt_cnt_q != PT_CNT_W'(1) ? S_PT : S_FINAL;
      end
      S_FINAL: begin
        phase_d = PH_FINAL;
        state_d = hdr_xfer ? S_INIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= PH_BUBBLE;
      new_q <= 1'b0;
      key_q <= '0;
      j0_q <= '0;
      size_q <= '0;
      cb_q <= '0;
      aad_cnt_q <= '0;
      pt_cnt_q <= '0;
      key_out_q <= '0;
      j0_out_q <= '0;
      size_out_q <= '0;
      cb_out_q <= '0;
      pt_out_q <= '0;
      aad_out_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      new_q <= new_d;
      key_q <= key_d;
      j0_q <= j0_d;
      size_q <= size_d;
      cb_q <= cb_d;
      aad_cnt_q <= aad_cnt_d;
      pt_cnt_q <= pt_cnt_d;
      key_out_q <= key_out_d;
      j0_out_q <= j0_out_d;
      size_out_q <= size_out_d;
      cb_out_q <= cb_out_d;
      pt_out_q <= pt_out_d;
      aad_out_q <= aad_out_d;
    end
  end
endmodule

// File: tb/tb_aes_gcm_pipeline_scheduler.sv
// tb_aes_gcm_pipeline_scheduler: slot-stream scoreboard plus directed timing and CB checks
module tb_aes_gcm_pipeline_scheduler;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic hdr_valid = 0, hdr_ready, aad_valid, aad_ready, pt_valid, pt_ready;
  logic [1407:0] hdr_key = '0, o_key;
  logic [127:0] hdr_j0 = '0, hdr_size = '0, aad_in, pt_in;
  logic [15:0] hdr_aad = '0;
  logic [31:0] hdr_pt = '0;
  logic o_new, o_busy;
  logic [2:0] o_phase;
  logic [127:0] o_pt, o_aad, o_h, o_j0, o_cb, o_size;
  aes_gcm_pipeline_scheduler dut (
    .clk(clk), .rst(rst), .i_hdr_valid(hdr_valid), .o_hdr_ready(hdr_ready),
    .i_hdr_key_schedule(hdr_key), .i_hdr_j0(hdr_j0), .i_hdr_aad_blocks(hdr_aad),
    .i_hdr_pt_blocks(hdr_pt), .i_hdr_instance_size(hdr_size),
    .i_aad_valid(aad_valid), .o_aad_ready(aad_ready), .i_aad(aad_in),
    .i_pt_valid(pt_valid), .o_pt_ready(pt_ready), .i_pt(pt_in),
    .o_new_instance(o_new), .o_phase(o_phase), .o_key_schedule(o_key),
    .o_plain_text(o_pt), .o_aad(o_aad), .o_h(o_h), .o_j0(o_j0), .o_cb(o_cb),
    .o_instance_size(o_size), .o_busy(o_busy)
  );
  typedef struct {
    logic [2:0] ph;
    logic nw;
    logic [127:0] cb, aad, pt, j0, sz;
    logic [1407:0] key;
  } slot_t;
  typedef struct {int ph; int cyc; logic [127:0] cb;} log_t;
  slot_t exp_q[$];
  log_t slog[$];
  int errors = 0, checks = 0, cyc = 0;
  int aad_idx = 0, pt_idx = 0, m_aad = 0, m_pt = 0, stall = 0, stall_at = -1;
  logic aad_en = 0, pt_en = 0, run = 0, seen_rdy = 0;
  function automatic logic [127:0] mk_aad(int k);
    return {32'hAAD0_0000, 64'h0, k[31:0]};
  endfunction
  function automatic logic [127:0] mk_pt(int k);
    return {32'h5050_0000, 64'h1234, k[31:0]};
  endfunction
  assign aad_in = mk_aad(aad_idx);
  assign pt_in = mk_pt(pt_idx);
  assign aad_valid = aad_en;
  assign pt_valid = pt_en && stall == 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (aad_valid && aad_ready) aad_idx <= aad_idx + 1;
    if (pt_valid && pt_ready) begin
      pt_idx <= pt_idx + 1;
      if (pt_idx == stall_at) stall <= 2;
    end else if (stall > 0) stall <= stall - 1;
  end
  task automatic check(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  // expected slot stream of one instance, straight from the phase/CB rules
  task automatic push_inst(input logic [127:0] j0, sz, input logic [1407:0] key, input int na, np);
    slot_t s;
    logic [127:0] c;
    s = '{ph: 3'd1, nw: 1'b1, cb: j0, aad: '0, pt: '0, j0: j0, sz: sz, key: key};
    exp_q.push_back(s);
    s.nw = 1'b0;
    for (int i = 0; i < na; i++) begin
      s.ph = 3'd2; s.cb = '0; s.aad = mk_aad(m_aad); m_aad++;
      exp_q.push_back(s);
    end
    c = j0;
    s.aad = '0;
    for (int i = 0; i < np; i++) begin
      c[31:0] = c[31:0] + 32'd1;
      s.ph = 3'd3; s.cb = c; s.pt = mk_pt(m_pt); m_pt++;
      exp_q.push_back(s);
    end
    s.ph = 3'd4; s.cb = '0; s.pt = '0;
    exp_q.push_back(s);
  endtask
  always @(negedge clk) if (run && !rst) begin
    if (aad_ready || pt_ready) seen_rdy = 1;
    check(!(aad_ready && pt_ready), "ready_exclusive", 128'({aad_ready, pt_ready}), 128'(0));
    check(o_h == '0, "h_zero", o_h, '0);
    if (o_phase != 3'd0) begin
      slog.push_back('{ph: int'(o_phase), cyc: cyc, cb: o_cb});
      if (exp_q.size() == 0) check(0, "unexpected_slot", 128'(o_phase), 128'(0));
      else begin
        slot_t e;
        e = exp_q.pop_front();
        check(o_phase == e.ph, "phase", 128'(o_phase), 128'(e.ph));
        check(o_new == e.nw, "new_instance", 128'(o_new), 128'(e.nw));
        if (e.ph == 3'd1 || e.ph == 3'd3) check(o_cb == e.cb, "cb", o_cb, e.cb);
        check(o_aad == e.aad, "aad", o_aad, e.aad);
        check(o_pt == e.pt, "plain_text", o_pt, e.pt);
        check(o_j0 == e.j0, "j0", o_j0, e.j0);
        check(o_size == e.sz, "instance_size", o_size, e.sz);
        check(o_key == e.key, "key_schedule", o_key[127:0], e.key[127:0]);
      end
    end else check(!o_new && o_aad == '0 && o_pt == '0, "bubble_clean", 128'({o_new, o_aad[0], o_pt[0]}), 128'(0));
  end
  task automatic send_hdr(input logic [127:0] j0, input int na, np, output int acc);
    @(negedge clk);
    hdr_j0 = j0;
    hdr_size = {64'(na * 128), 64'(np * 128)};
    hdr_key = {11{j0 ^ 128'h5A5A}};
    hdr_aad = 16'(na);
    hdr_pt = 32'(np);
    hdr_valid = 1;
    push_inst(hdr_j0, hdr_size, hdr_key, na, np);
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      if (hdr_ready) begin
        acc = cyc;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    #1 hdr_valid = 0;
    if (acc < 0) check(0, "hdr_accept_timeout", '0, 128'(1));
  endtask
  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      #1 done = exp_q.size() == 0 && !o_busy;
    end
    if (!done) begin
      check(0, "idle_timeout", 128'(exp_q.size()), '0);
      exp_q.delete();
    end
  endtask
  task automatic fresh();
    @(negedge clk);
    #1 slog.delete();
    seen_rdy = 0;
  endtask
  task automatic check_reset_outputs(input string nm);
    check(o_phase == 0 && !o_new && !o_busy, {nm, "_ctrl"}, 128'({o_phase, o_new, o_busy}), '0);
    check(o_pt == '0 && o_aad == '0 && o_cb == '0 && o_j0 == '0 && o_size == '0 && o_key == '0,
          {nm, "_data"}, o_j0 | o_cb | o_pt, '0);
    check(!hdr_ready && !aad_ready && !pt_ready, {nm, "_readies"}, 128'({hdr_ready, aad_ready, pt_ready}), '0);
  endtask
  int acc, acc2;
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;
    @(negedge clk);
    check(hdr_ready == 1 && o_phase == 0, "post_reset", 128'({hdr_ready, o_phase}), 128'(4'b1000));
    run = 1;
    aad_en = 1;
    pt_en = 1;
    fresh();
    send_hdr({96'hC0FFEE00_11223344_55667788, 32'h1}, 1, 2, acc);
    wait_idle();
    check(slog.size() == 5, "basic_count", 128'(slog.size()), 128'(5));
    if (slog.size() == 5) begin
      check(slog[0].ph == 1 && slog[1].ph == 2 && slog[2].ph == 3 && slog[3].ph == 3 && slog[4].ph == 4,
            "basic_phases", 128'(slog[1].ph), 128'(2));
      check(slog[4].cyc - slog[0].cyc == 4, "basic_back_to_back", 128'(slog[4].cyc - slog[0].cyc), 128'(4));
      check(slog[0].cyc == acc + 2, "init_latency", 128'(slog[0].cyc - acc), 128'(2));
      check(slog[0].cb[31:0] == 32'h1 && slog[2].cb[31:0] == 32'h2 && slog[3].cb[31:0] == 32'h3,
            "basic_cb_literal", {slog[0].cb[31:0], slog[2].cb[31:0], slog[3].cb[31:0]}, 128'h1_00000002_00000003);
    end
    fresh();
    send_hdr(128'h0123_4567_89AB_CDEF_0000_0000_0000_0042, 0, 0, acc);
    wait_idle();
    check(slog.size() == 2 && slog[0].ph == 1 && slog[1].ph == 4 && slog[1].cyc == slog[0].cyc + 1,
          "empty_phases", 128'(slog.size()), 128'(2));
    check(seen_rdy == 0, "empty_no_data_ready", 128'(seen_rdy), '0);
    fresh();
    send_hdr({96'hDEAD_BEEF_0000_1111_2222_3333, 32'hFFFF_FFFE}, 0, 3, acc);
    wait_idle();
    check(slog.size() == 5, "wrap_count", 128'(slog.size()), 128'(5));
    if (slog.size() == 5) begin
      check(slog[1].cb[31:0] == 32'hFFFF_FFFF && slog[2].cb[31:0] == 32'h0 && slog[3].cb[31:0] == 32'h1,
            "wrap_cb_literal", {slog[1].cb[31:0], slog[2].cb[31:0], slog[3].cb[31:0]}, 128'hFFFFFFFF_00000000_00000001);
      check(slog[2].cb[127:32] == 96'hDEAD_BEEF_0000_1111_2222_3333, "wrap_upper", slog[2].cb, 128'hDEAD_BEEF_0000_1111_2222_3333_0000_0000);
    end
    fresh();
    stall_at = pt_idx + 1;
    send_hdr(128'h10, 0, 4, acc);
    wait_idle();
    stall_at = -1;
    check(slog.size() == 6, "stall_count", 128'(slog.size()), 128'(6));
    if (slog.size() == 6) begin
      check(slog[3].cyc - slog[2].cyc == 3, "stall_two_bubbles", 128'(slog[3].cyc - slog[2].cyc), 128'(3));
      check(slog[4].cyc - slog[3].cyc == 1, "stall_resume", 128'(slog[4].cyc - slog[3].cyc), 128'(1));
      check(slog[4].cb[31:0] == 32'h14, "stall_cb_literal", slog[4].cb, 128'h14);
    end
    fresh();
    send_hdr(128'hAAAA_0000_0000_0000_0000_0000_0000_0100, 2, 1, acc);
    send_hdr(128'hBBBB_0000_0000_0000_0000_0000_0000_0200, 0, 1, acc2);
    wait_idle();
    check(slog.size() == 8, "b2b_count", 128'(slog.size()), 128'(8));
    if (slog.size() == 8) begin
      check(slog[4].ph == 4 && slog[5].ph == 1 && slog[5].cyc == slog[4].cyc + 1, "b2b_adjacent",
            128'(slog[5].cyc - slog[4].cyc), 128'(1));
      check(slog[6].cb[31:0] == 32'h201, "b2b_cb_literal", slog[6].cb, 128'h201);
    end
    fresh();
    send_hdr(128'h77, 0, 4, acc);
    for (int i = 0; i < 100; i++) begin
      int n = 0;
      @(negedge clk);
      #1;
      foreach (slog[k]) if (slog[k].ph == 3) n++;
      if (n >= 2) break;
    end
    rst = 1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    exp_q.delete();
    rst = 0;
    @(negedge clk);
    check(hdr_ready == 1 && o_phase == 0 && !o_busy, "mid_reset_release", 128'({hdr_ready, o_phase, o_busy}), 128'(5'b10000));
    m_pt = pt_idx;
    fresh();
    send_hdr(128'h99, 0, 1, acc);
    wait_idle();
    check(slog.size() == 3 && slog[1].cb[31:0] == 32'h9A, "after_reset_cb", slog.size() == 3 ? slog[1].cb : '0, 128'h9A);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_gcm_pipeline_scheduler.md
Name: aes_gcm_pipeline_scheduler

Overview:
Front-end sequencer for the AES-GCM encrypt pipeline. It accepts one instance header (key schedule, J0, block counts, length block) and then streams of AAD and plaintext blocks over valid/ready. It emits exactly one pipeline slot per clock, tagged with a phase code, a new-instance flag and the counter block CB, and inserts bubbles when input data is starved. It drives the first pipeline stage inputs directly: plain text, AAD, H seed, J0, CB, instance size, key schedule, phase and new-instance.

Parameters:
AAD_CNT_W, 16, width of the AAD block count field
PT_CNT_W, 32, width of the plaintext block count field

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
i_hdr_valid  in  1  header valid
o_hdr_ready  out  1  header ready
i_hdr_key_schedule  in  [0:1407]  expanded key, 11 round keys
i_hdr_j0  in  [0:127]  pre-counter block J0
i_hdr_aad_blocks  in  AAD_CNT_W  number of 128-bit AAD blocks
i_hdr_pt_blocks  in  PT_CNT_W  number of 128-bit plaintext blocks
i_hdr_instance_size  in  [0:127]  GCM length block, len(A)||len(C)
i_aad_valid / o_aad_ready  in/out  1  AAD stream handshake
i_aad  in  [0:127]  AAD block
i_pt_valid / o_pt_ready  in/out  1  plaintext stream handshake
i_pt  in  [0:127]  plaintext block
o_new_instance  out  1  first slot of an instance
o_phase  out  [0:2]  slot phase code
o_key_schedule  out  [0:1407]  key schedule for the current instance
o_plain_text  out  [0:127]  plaintext for PT slots, else 0
o_aad  out  [0:127]  AAD for AAD slots, else 0
o_h  out  [0:127]  H seed, constant all-zero block
o_j0  out  [0:127]  J0 of the current instance
o_cb  out  [0:127]  counter block for this slot
o_instance_size  out  [0:127]  length block of the current instance
o_busy  out  1  state is not IDLE

Behaviour:
- Phase codes: 0 BUBBLE, 1 INIT, 2 AAD, 3 PT, 4 FINAL. Codes 5-7 are never driven.
- Handshake rules:
  - A transfer happens when valid and ready are both high in the same cycle.
  - Readies are decoded from state only; they never depend on valid.
  - o_aad_ready and o_pt_ready are never high together.
  - While rst is high, all readies are 0.
- FSM states: IDLE, INIT, AAD, PT, FINAL.
  - IDLE: o_hdr_ready=1. A header transfer captures all header fields and sets cb_reg=inc32(J0). Next state is INIT.
  - INIT: issues a phase-1 slot with o_new_instance=1 and o_cb=J0. Next state is AAD if aad_blocks>0, else PT if pt_blocks>0, else FINAL.
  - AAD: o_aad_ready=1.
    - On transfer: issue a phase-2 slot with o_aad=i_aad and decrement the AAD count.
    - Without a transfer: issue a phase-0 bubble.
    - After the last AAD block: go to PT if pt_blocks>0, else FINAL.
  - PT: o_pt_ready=1.
    - On transfer: issue a phase-3 slot with o_plain_text=i_pt and o_cb=cb_reg, then set cb_reg<=inc32(cb_reg).
    - Without a transfer: issue a phase-0 bubble and leave cb_reg unchanged.
    - After the last PT block: go to FINAL.
  - FINAL: issues a phase-4 slot. o_hdr_ready=1.
    - A header transfer in this cycle goes to INIT, giving back-to-back instances with no bubble.
    - Otherwise go to IDLE.
  - IDLE always emits phase-0 slots.
- Latency: all slot outputs are registered. A slot decided in cycle t appears on the outputs in cycle t+1. A header accepted in IDLE at cycle t produces the INIT slot on the outputs at t+2.
- Held outputs: o_key_schedule, o_j0 and o_instance_size hold the current instance's captured values on every slot, including bubbles.
- inc32: bits [96:127] increment modulo 2^32; bits [0:95] are unchanged. 0xFFFFFFFF wraps to 0x00000000.
- Reset values: o_phase=0, o_new_instance=0, all data outputs 0, o_busy=0, state IDLE, counters 0.
- Reset mid-instance:
  - The next cycle's outputs are the reset values and the partial instance is dropped.
  - Slots already issued drain through the reset-less pipeline. Downstream discards them until the next o_new_instance.
- o_new_instance is high only on phase-1 slots.

Decomposition:
- Shared package aes_gcm_pkg holds:
  - Phase localparams/enum: PH_BUBBLE=0, PH_INIT=1, PH_AAD=2, PH_PT=3, PH_FINAL=4.
  - BLOCK_W=128 and KEY_SCHED_W=1408.
  - Function fn_inc32.
- Single module; no sub-module required.

Test Plan:
- Reset: rst high for 2 cycles → all outputs 0 and all readies 0; the cycle after release o_hdr_ready=1 and o_phase=0.
- J0=0x…00000001, aad=1, pt=2, all valids high → phases 1,2,3,3,4 on consecutive cycles; o_cb = …01, …02, …03 on the INIT, PT, PT slots; o_new_instance only on the phase-1 slot.
- aad=0, pt=0 → phases 1,4 only; o_aad_ready and o_pt_ready never asserted.
- J0 low word 0xFFFFFFFE, pt=3 → PT slot CBs low words 0xFFFFFFFF, 0x00000000, 0x00000001; upper 96 bits equal J0.
- pt=4 with i_pt_valid low for 2 cycles after the 2nd block → exactly two phase-0 slots between PT slots 2 and 3; CB sequence stays contiguous.
- Two scenarios:
  - Second header held valid → accepted in the FINAL cycle; its phase-1 slot directly follows phase 4.
  - rst pulsed during PT → next-cycle outputs 0 and o_hdr_ready=1 after release.
